// File: rtl/seg_display_scheduler.sv
// Time-shares a two-digit decimal readout between cursor X, cursor Y and colour,
// with a one-shot flash override that pre-empts the rotation for a fixed hold.
module seg_display_scheduler #(
   parameter int DWELL      = 25_000_000,
   parameter int FLASH_HOLD = 50_000_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [5:0] i_x_pos,
   input  logic [5:0] i_y_pos,
   input  logic [5:0] i_color,
   input  logic       i_freeze,
   input  logic       i_req_flash,
   input  logic [5:0] i_flash_val,
   output logic [5:0] o_disp_value,
   output logic [1:0] o_disp_sel,
   output logic       o_disp_blank
);

   localparam int DW = $clog2(DWELL);
   localparam int HW = (FLASH_HOLD > 1) ? $clog2(FLASH_HOLD) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(FLASH_HOLD - 1);

   typedef enum logic {ST_ROTATE, ST_FLASH} state_t;

   state_t          r_state, w_state;
   logic [1:0]      r_slot, w_slot;
   logic [DW-1:0]   r_dwell_cnt, w_dwell_cnt;
   logic [HW-1:0]   r_hold_cnt, w_hold_cnt;
   logic [5:0]      r_flash_reg, w_flash_reg;
   logic [5:0]      r_disp_value, w_disp_value;
   logic [1:0]      r_disp_sel, w_disp_sel;
   logic            r_disp_blank;
   logic [5:0]      w_src;

   always_comb begin
      case (r_slot)
         2'd0:    w_src = i_x_pos;
         2'd1:    w_src = i_y_pos;
         default: w_src = i_color;
      endcase
   end

   always_comb begin
      w_state      = r_state;
      w_slot       = r_slot;
      w_dwell_cnt  = r_dwell_cnt;
      w_hold_cnt   = r_hold_cnt;
      w_flash_reg  = r_flash_reg;
      w_disp_value = r_disp_value;
      w_disp_sel   = r_disp_sel;
      if (i_req_flash) begin
         // A new request always wins, whether rotating or already flashing.
         w_state      = ST_FLASH;
         w_flash_reg  = i_flash_val;
         w_hold_cnt   = '0;
         w_disp_value = i_flash_val;
         w_disp_sel   = 2'd3;
      end else begin
         case (r_state)
            ST_ROTATE: begin
               w_disp_value = w_src;
               w_disp_sel   = r_slot;
               if (!i_freeze) begin
                  if (r_dwell_cnt == DWELL_LAST) begin
                     w_dwell_cnt = '0;
                     w_slot      = (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
                  end else begin
                     w_dwell_cnt = r_dwell_cnt + DW'(1);
                  end
               end
            end
            default: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  // The expiry cycle already loads the resumed slot, so it counts
                  // as dwell step 0; the slot is then visible for a full DWELL.
                  w_state      = ST_ROTATE;
                  w_dwell_cnt  = DW'(1);
                  w_disp_value = w_src;
                  w_disp_sel   = r_slot;
               end else begin
                  w_hold_cnt   = r_hold_cnt + HW'(1);
                  w_disp_value = r_flash_reg;
                  w_disp_sel   = 2'd3;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_ROTATE;
         r_slot       <= 2'd0;
         r_dwell_cnt  <= '0;
         r_hold_cnt   <= '0;
         r_flash_reg  <= '0;
         r_disp_value <= '0;
         r_disp_sel   <= 2'd0;
         r_disp_blank <= 1'b1;
      end else begin
         r_state      <= w_state;
         r_slot       <= w_slot;
         r_dwell_cnt  <= w_dwell_cnt;
         r_hold_cnt   <= w_hold_cnt;
         r_flash_reg  <= w_flash_reg;
         r_disp_value <= w_disp_value;
         r_disp_sel   <= w_disp_sel;
         r_disp_blank <= 1'b0;
      end
   end

   assign o_disp_value = r_disp_value;
   assign o_disp_sel   = r_disp_sel;
   assign o_disp_blank = r_disp_blank;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler (DWELL=4, FLASH_HOLD=3): expected
// outputs are queued as each cycle is driven and checked after the next edge.
module tb_seg_display_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] x_pos, y_pos, color, flash_val;
   logic       freeze, req_flash;
   logic [5:0] disp_value;
   logic [1:0] disp_sel;
   logic       disp_blank;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [8:0] sb_q[$];

   always #5 clk = ~clk;

   seg_display_scheduler #(.DWELL(4), .FLASH_HOLD(3)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_x_pos      (x_pos),
      .i_y_pos      (y_pos),
      .i_color      (color),
      .i_freeze     (freeze),
      .i_req_flash  (req_flash),
      .i_flash_val  (flash_val),
      .o_disp_value (disp_value),
      .o_disp_sel   (disp_sel),
      .o_disp_blank (disp_blank)
   );

   // Queue the output expected after the coming edge, advance one cycle, check it.
   task automatic cyc(input string tag, input logic [1:0] s, input logic [5:0] v,
                      input logic b);
      logic [8:0] exp_w, obs_w;
      sb_q.push_back({s, v, b});
      @(posedge clk);
      #1;
      exp_w = sb_q.pop_front();
      obs_w = {disp_sel, disp_value, disp_blank};
      n_cmp++;
      assert (obs_w === exp_w) else begin
         n_fail++;
         $error("FAIL %s: got sel=%0d val=%0d blank=%0d, want sel=%0d val=%0d blank=%0d",
                tag, obs_w[8:7], obs_w[6:1], obs_w[0], exp_w[8:7], exp_w[6:1], exp_w[0]);
      end
   endtask

   task automatic rot(input string tag, input int n, input logic [1:0] s,
                      input logic [5:0] v);
      for (int i = 0; i < n; i++) cyc(tag, s, v, 1'b0);
   endtask

   initial begin
      reset = 1'b1; x_pos = 6'd31; y_pos = 6'd21; color = 6'd15;
      freeze = 1'b0; req_flash = 1'b0; flash_val = 6'd0;

      cyc("reset0", 2'd0, 6'd0, 1'b1);
      cyc("reset1", 2'd0, 6'd0, 1'b1);
      reset = 1'b0;

      // Plain rotation: four outputs per slot after the blanked cycle.
      rot("rot_x", 4, 2'd0, 6'd31);
      rot("rot_y", 4, 2'd1, 6'd21);
      rot("rot_c", 4, 2'd2, 6'd15);

      // Live tracking of x during slot 0.
      cyc("live_pre", 2'd0, 6'd31, 1'b0);
      x_pos = 6'd10;
      rot("live_x", 3, 2'd0, 6'd10);

      // Freeze 5 cycles mid slot 1: slot 1 shows for 9 cycles in total.
      rot("frz_pre", 2, 2'd1, 6'd21);
      freeze = 1'b1;
      rot("frz_hold", 5, 2'd1, 6'd21);
      freeze = 1'b0;
      rot("frz_post", 2, 2'd1, 6'd21);
      rot("frz_adv", 4, 2'd2, 6'd15);
      rot("rot_x2", 4, 2'd0, 6'd10);

      // Flash pre-empt in slot 1; flash_val changes afterwards must not leak.
      cyc("fl_pre", 2'd1, 6'd21, 1'b0);
      req_flash = 1'b1; flash_val = 6'd63;
      cyc("fl_t1", 2'd3, 6'd63, 1'b0);
      req_flash = 1'b0; flash_val = 6'd5;
      rot("fl_hold", 2, 2'd3, 6'd63);
      rot("fl_resume", 4, 2'd1, 6'd21);

      // Flash collides with slot 2 dwell expiry: slot 2 resumes with full dwell.
      rot("col_pre", 3, 2'd2, 6'd15);
      req_flash = 1'b1; flash_val = 6'd1;
      cyc("col_t1", 2'd3, 6'd1, 1'b0);
      req_flash = 1'b0;
      rot("col_hold", 2, 2'd3, 6'd1);
      rot("col_resume", 4, 2'd2, 6'd15);
      rot("col_next", 4, 2'd0, 6'd10);

      // Second request during the flash restarts the hold with the new value.
      req_flash = 1'b1; flash_val = 6'd7;
      cyc("re_t1", 2'd3, 6'd7, 1'b0);
      req_flash = 1'b0;
      cyc("re_first", 2'd3, 6'd7, 1'b0);
      req_flash = 1'b1; flash_val = 6'd0;
      cyc("re_t2", 2'd3, 6'd0, 1'b0);
      req_flash = 1'b0; flash_val = 6'd50;
      rot("re_hold", 2, 2'd3, 6'd0);
      rot("re_resume", 2, 2'd1, 6'd21);

      // Request on the hold-expiry cycle keeps the block in FLASH.
      req_flash = 1'b1; flash_val = 6'd9;
      cyc("hx_t1", 2'd3, 6'd9, 1'b0);
      req_flash = 1'b0;
      rot("hx_hold", 2, 2'd3, 6'd9);
      req_flash = 1'b1; flash_val = 6'd12;
      cyc("hx_restart", 2'd3, 6'd12, 1'b0);
      req_flash = 1'b0;
      cyc("hx_hold2", 2'd3, 6'd12, 1'b0);

      // Reset mid-flash with a coincident request: request is dropped.
      reset = 1'b1; req_flash = 1'b1; flash_val = 6'd44;
      cyc("rst_flash", 2'd0, 6'd0, 1'b1);
      reset = 1'b0; req_flash = 1'b0;
      rot("rst_rot_x", 4, 2'd0, 6'd10);
      cyc("rst_rot_y", 2'd1, 6'd21, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-shares the single two-digit decimal seven-segment readout (HEX1/HEX0) between the game's status sources: cursor X, cursor Y and selected colour index. The sources rotate on a fixed dwell period. A one-shot "flash" request can pre-empt the rotation to show an event value for a fixed hold time. The block sits between the game-state registers and the two-digit decimal decoder: it drives the 6-bit value that the decoder converts to HEX1/HEX0, plus a blank control.

## Interface
Parameters:
- DWELL, 25_000_000: cycles each rotation slot is displayed; must be ≥ 2.
- FLASH_HOLD, 50_000_000: cycles a flash value is displayed; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- x_pos  in  6  cursor X, 0–63; slot 0 source.
- y_pos  in  6  cursor Y, 0–63; slot 1 source.
- color  in  6  colour index, 0–63; slot 2 source.
- freeze  in  1  level; pauses rotation while high.
- req_flash  in  1  single-cycle pulse requesting a flash.
- flash_val  in  6  value to flash; sampled only when req_flash = 1.
- disp_value  out  6  value to the decimal decoder.
- disp_sel  out  2  source shown: 0 = X, 1 = Y, 2 = colour, 3 = flash.
- disp_blank  out  1  1 = decoder output forced dark.

## Operation
- Two states:
  - ROTATE: shows slot sources.
  - FLASH: shows the captured flash value.
- Internal registers:
  - slot: 2 bits, values 0–2.
  - dwell_cnt: counts 0..DWELL-1, width $clog2(DWELL).
  - hold_cnt: counts 0..FLASH_HOLD-1.
  - flash_reg: 6 bits.
- ROTATE behaviour:
  - Each cycle, register the current live value of the selected source into disp_value; disp_sel = slot.
  - dwell_cnt increments each cycle unless freeze = 1 (freeze holds dwell_cnt and slot).
  - When dwell_cnt = DWELL-1 and freeze = 0:
    - dwell_cnt clears to 0.
    - slot advances 0→1→2→0. Slot 2 wraps to 0; slot value 3 is never entered.
- ROTATE → FLASH on req_flash = 1:
  - Capture flash_val into flash_reg.
  - Clear hold_cnt.
  - Leave slot unchanged; it is the slot to resume.
- FLASH behaviour:
  - disp_value = flash_reg, disp_sel = 3.
  - hold_cnt increments each cycle; freeze has no effect.
- FLASH → ROTATE when hold_cnt = FLASH_HOLD-1:
  - Resume the saved slot with dwell_cnt cleared to 0, so the interrupted slot gets a full dwell.
- req_flash while in FLASH: recapture flash_val and clear hold_cnt. The new value is shown for a full FLASH_HOLD from that point.
- Simultaneous req_flash and dwell expiry in ROTATE: the flash wins. slot does NOT advance; the expiring slot resumes after the flash with a full dwell.
- Simultaneous req_flash and hold expiry in FLASH: the flash restart wins; the block stays in FLASH.
- disp_blank:
  - 1 during reset and on the first cycle after reset deasserts.
  - 0 otherwise.
- No arithmetic on source values; they pass through unmodified. Range 0–63 is guaranteed by width.

## Timing
- All outputs are registered. Latency from source or flash_val sample to disp_value is 1 cycle.
- Reset values:
  - state = ROTATE, slot = 0, dwell_cnt = 0, hold_cnt = 0, flash_reg = 0.
  - disp_value = 0, disp_sel = 0, disp_blank = 1.
- Post-reset timing:
  - First cycle after reset release: disp_blank = 1; x_pos is captured.
  - Second cycle: disp_blank = 0, disp_value = x_pos.
  - The slot 0 dwell count starts on the first cycle after release.
- Slot duration: each unfrozen slot shows for exactly DWELL cycles. disp_sel changes 1 cycle after the cycle where dwell_cnt = DWELL-1.
- Flash timing:
  - req_flash high in cycle t → disp_sel = 3 and disp_value = flash_val(t) from cycle t+1.
  - The flash lasts FLASH_HOLD cycles.
  - disp_sel returns to the saved slot at t+1+FLASH_HOLD.
- Reset mid-flash or mid-freeze: reset dominates all inputs and returns the block to reset values on the next edge. A req_flash present in the reset cycle is dropped.

## Test plan
Bench uses DWELL = 4, FLASH_HOLD = 3.
- Reset then rotate: x = 31, y = 21, color = 15, freeze = 0 → disp_blank = 1 for 1 post-reset cycle. Then disp_sel sequence 0,0,0,0 / 1×4 / 2×4 / 0…, with disp_value 31 / 21 / 15 respectively.
- Live tracking: during slot 0, change x_pos 31 → 10 → disp_value = 10 one cycle later; disp_sel stays 0.
- Freeze: assert freeze for 5 cycles mid-slot 1 → disp_sel holds 1 for 4 + 5 cycles total, then advances to 2.
- Flash pre-empt: pulse req_flash with flash_val = 63 in the 2nd cycle of slot 1 → disp_sel = 3, disp_value = 63 for 3 cycles. Then disp_sel = 1 for a full 4 cycles, then 2.
- Collisions:
  - req_flash (flash_val = 1) on the last cycle of slot 2 → flash shows 1 for 3 cycles, then slot 2 again for 4 cycles, then slot 0.
  - Second req_flash (flash_val = 0) in the 2nd flash cycle → value 0 is held for 3 more cycles.
- Reset mid-flash: assert reset during a flash → next cycle disp_value = 0, disp_sel = 0, disp_blank = 1. Rotation restarts at slot 0.
